// File: rtl/noc_packet_tx.sv
// Transmit-side NoC packetizer: turns a request plus a payload word stream into
// one header flit followed by payload flits, with last on the final flit.
module noc_packet_tx #(
    parameter int FLIT_WIDTH  = 32,
    parameter int DEST_WIDTH  = 5,
    parameter int CLASS_WIDTH = 3,
    parameter int SRC_ID      = 0,
    parameter int MAX_LEN     = 14,
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DEST_WIDTH-1:0]  req_dest,
    input  logic [CLASS_WIDTH-1:0] req_class,
    input  logic [LEN_WIDTH-1:0]   req_len,
    input  logic [FLIT_WIDTH-1:0]  pl_data,
    input  logic                   pl_valid,
    output logic                   pl_ready,
    output logic [FLIT_WIDTH-1:0]  out_flit,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   err_len
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE_L     = LEN_WIDTH'(1);

    logic [1:0]             state;
    logic [DEST_WIDTH-1:0]  dest_r;
    logic [CLASS_WIDTH-1:0] class_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   free;
    logic                   pl_fire;

    // Header: dest | class | src | zero fill | len, MSB first.
    function automatic logic [FLIT_WIDTH-1:0] build_header(
        input logic [DEST_WIDTH-1:0]  d,
        input logic [CLASS_WIDTH-1:0] c,
        input logic [LEN_WIDTH-1:0]   l
    );
        logic [FLIT_WIDTH-1:0] h;
        h = '0;
        h[FLIT_WIDTH-1 -: DEST_WIDTH] = d;
        h[FLIT_WIDTH-DEST_WIDTH-1 -: CLASS_WIDTH] = c;
        h[FLIT_WIDTH-DEST_WIDTH-CLASS_WIDTH-1 -: DEST_WIDTH] = SRC_ID[DEST_WIDTH-1:0];
        h[LEN_WIDTH-1:0] = l;
        return h;
    endfunction

    assign free      = ~out_valid | out_ready;
    assign req_ready = rst & (state == IDLE);
    assign pl_ready  = rst & (state == PAYLOAD) & free;
    assign pl_fire   = pl_valid & pl_ready;
    assign busy      = (state != IDLE) | out_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_flit  <= '0;
            err_len   <= 1'b0;
            remaining <= '0;
            dest_r    <= '0;
            class_r   <= '0;
            len_r     <= '0;
        end else begin
            err_len <= 1'b0;
            // A completed transfer empties the register unless a load below refills it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_len > MAX_LEN_L) begin
                            err_len <= 1'b1;
                        end else begin
                            dest_r    <= req_dest;
                            class_r   <= req_class;
                            len_r     <= req_len;
                            remaining <= req_len;
                            state     <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (free) begin
                        out_flit  <= build_header(dest_r, class_r, len_r);
                        out_valid <= 1'b1;
                        out_last  <= (len_r == '0);
                        state     <= (len_r == '0) ? IDLE : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (remaining == '0) begin
                        state <= IDLE;
                    end else if (pl_fire) begin
                        out_flit  <= pl_data;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == ONE_L);
                        remaining <= remaining - ONE_L;
                        if (remaining == ONE_L) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
